// File: rtl/psum_packetizer_if.sv
// psum_packetizer_if: bundles the partial-sum input handshake, the packet
// output handshake and the round/error status of the packetizer.
// The slave modport is the packetizer's view; master is the PE/router side.
interface psum_packetizer_if #(
  parameter int WIDTH    = 39,
  parameter int WIDTH_IN = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_col;
  logic [WIDTH_IN-1:0] in_psum;
  logic                pkt_valid;
  logic                pkt_ready;
  logic [WIDTH-1:0]    pkt_data;
  logic                round_done;
  logic [2:0]          round_id;
  logic                err;

  modport slave (
    input  in_valid, in_col, in_psum, pkt_ready,
    output in_ready, pkt_valid, pkt_data, round_done, round_id, err
  );

  modport master (
    output in_valid, in_col, in_psum, pkt_ready,
    input  in_ready, pkt_valid, pkt_data, round_done, round_id, err
  );
endinterface

// File: rtl/psum_packetizer.sv
// psum_packetizer: turns per-column PE partial sums into row-adder NoC
// packets, three partials per column per round, buffered in a small FIFO.
// Optional macro PSUM_SAT_EN: clamp raw partials above the field range to
// all-ones instead of truncating them.
module psum_packetizer #(
  parameter int         WIDTH      = 39,
  parameter int         WIDTH_IN   = 12,
  parameter int         WIDTH_D    = 8,
  parameter logic [3:0] SRC_ADDR   = 4'b0000,
  parameter logic [3:0] DEST_ADDR  = 4'b0001,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psum_packetizer_if.slave     bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PAD_W = WIDTH - 15 - WIDTH_D;

  typedef enum logic {ST_EMPTY, ST_NONEMPTY} fifo_state_t;

  fifo_state_t        r_state;
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [2:0]         r_round_id;
  logic               r_round_done;
  logic               r_err;

  logic               w_full;
  logic               w_accept;
  logic               w_blocked;
  logic               w_push;
  logic               w_pop;
  logic               w_round_complete;
  logic [3:1]         w_hit;
  logic [3:1]         w_sat;
  logic [3:1]         w_done_after;
  logic [WIDTH_D-1:0] w_field;
  logic [WIDTH-1:0]   w_pkt;

`ifdef PSUM_SAT_EN
  assign w_field = (|bus.in_psum[WIDTH_IN-1:WIDTH_D]) ? {WIDTH_D{1'b1}}
                                                      : bus.in_psum[WIDTH_D-1:0];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^bus.in_psum[WIDTH_IN-1:WIDTH_D];
  assign w_field     = bus.in_psum[WIDTH_D-1:0];
`endif

  assign w_pkt = {2'b01, DEST_ADDR, SRC_ADDR, r_round_id, bus.in_col,
                  {PAD_W{1'b0}}, w_field};

  // Ready is withheld while reset is applied; no bypass, so a pop never
  // frees a slot within the same cycle.
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign bus.in_ready = rst_n & ~w_full;

  // Column 0 and any column already holding three partials are dropped but
  // still complete the handshake.
  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_blocked = (bus.in_col == 2'b00) | (|(w_hit & w_sat));
  assign w_push    = w_accept & ~w_blocked;
  assign w_pop     = (r_state == ST_NONEMPTY) & bus.pkt_ready;

  // The round closes when this push leaves every column at three.
  assign w_round_complete = w_push & (&w_done_after);

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_col
      logic [1:0] r_cnt;

      assign w_hit[gi]        = (bus.in_col == 2'(gi));
      assign w_sat[gi]        = (r_cnt == 2'd3);
      assign w_done_after[gi] = w_sat[gi] | ((r_cnt == 2'd2) & w_hit[gi]);

      // Per-column partial count, cleared when the round closes.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= 2'd0;
        end else if (w_round_complete) begin
          r_cnt <= 2'd0;
        end else if (w_push && w_hit[gi]) begin
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  endgenerate

  // Packet FIFO storage, pointers and EMPTY/NONEMPTY control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_pkt;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_state <= ST_NONEMPTY;
        end
        ST_NONEMPTY: begin
          if (w_pop && !w_push && (r_count == CNT_W'(1))) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Round number, one-cycle completion pulse and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_round_id   <= 3'd0;
      r_round_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_round_done <= w_round_complete;
      if (w_round_complete) r_round_id <= r_round_id + 3'd1;
      if (w_accept && w_blocked) r_err <= 1'b1;
    end
  end

  assign bus.pkt_valid  = (r_state == ST_NONEMPTY);
  assign bus.pkt_data   = r_mem[r_rd_ptr];
  assign bus.round_done = r_round_done;
  assign bus.round_id   = r_round_id;
  assign bus.err        = r_err;

endmodule
